ym_stereo_accum: RTL and testbench
==================================

# ym_stereo_accum

Parametrised stereo frame accumulator between the channel output stage and the DAC/host interface. Consumes the time-multiplexed per-channel output stream (offset-binary sample plus 2-bit pan), sums CH_COUNT channels per frame into signed left/right totals with saturation, and buffers completed frames in a small FIFO behind a valid/ready handshake. It generalises the fixed 9-bit per-slot MOL/MOR latch to arbitrary channel count, widths and buffering, with overflow and drop reporting.

## Interface
- CH_COUNT, 6, channels per frame (≥2)
- IN_W, 9, channel sample width, offset binary (zero = 1<<(IN_W-1))
- OUT_W, 16, signed two's-complement output width (≥IN_W)
- FIFO_DEPTH, 4, frame FIFO entries (power of two, ≥2)
- MCLK  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- ch_valid  in  1  ch_value/ch_pan valid this cycle
- ch_value  in  IN_W  channel sample, offset binary
- ch_pan  in  2  [1]=left enable, [0]=right enable
- frame_sync  in  1  current valid input is channel 0 of a new frame
- sample_valid  out  1  FIFO head valid
- sample_ready  in  1  consumer accepts head
- out_l, out_r  out  OUT_W  FIFO head samples, signed
- sat_flag  out  1  sticky: any saturation since reset
- drop_cnt  out  8  saturating count of frames dropped on full FIFO
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Conversion: signed = {~ch_value[IN_W-1], ch_value[IN_W-2:0]}, sign-extended to OUT_W+1.
- Per valid input: acc_l += pan[1] ? signed : 0; acc_r likewise with pan[0]. Accumulators OUT_W+1 bits plus clog2(CH_COUNT) guard bits; no intermediate wrap.
- Channel counter idx 0..CH_COUNT-1 advances on each ch_valid; wraps to 0 after CH_COUNT-1.
- frame_sync with ch_valid: partial frame discarded, input treated as idx 0 (acc = its contribution). frame_sync without ch_valid: partial discarded, acc cleared, idx=0.
- Frame completion (valid input at idx CH_COUNT-1, no frame_sync): final sum = acc + current contribution, clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]; clamp of either side sets sat_flag. Result pushed to FIFO; accumulators cleared same edge.
- FIFO: pop when sample_valid & sample_ready. Pop evaluated before push: push at full with simultaneous pop succeeds. Push at full without pop: frame dropped, drop_cnt += 1 (holds at 255), FIFO unchanged.
- Empty FIFO: sample_valid=0; out_l/out_r hold last popped value (0 after reset).
- Reset: acc=0, idx=0, FIFO empty, level=0, sample_valid=0, out_l=out_r=0, sat_flag=0, drop_cnt=0. Reset mid-frame discards all partial and buffered data; inputs ignored during reset.

## Timing
- Inputs sampled at rising MCLK when ch_valid=1; no input backpressure (stream is free-running).
- Latency: final channel sampled at edge E → frame at FIFO tail after E; if FIFO was empty, sample_valid=1 and out_l/out_r valid in cycle after E.
- out_l/out_r, sample_valid, level all registered; stable until pop edge.
- Pop and push on same edge: level unchanged; head advances correctly when level=1 (new frame becomes head).
- sat_flag and drop_cnt update on the completion edge.

## Structure
- Shared package ym_pkg: offset-to-signed conversion function, saturate function (width-parametric), pan bit index constants.
- One sub-module: ym_frame_fifo (parametrised width 2*OUT_W, depth FIFO_DEPTH, registered head, full/empty/level, pop-before-push rule). Accumulator/counter in top.

## Test plan
- Defaults, 6 channels value 0x110 all pan=2'b11, ready=1 → one frame, out_l=out_r=96, sample_valid one cycle after 6th input.
- Pan split: ch0 0x1FF pan=10, ch1 0x000 pan=01, others 0x100 pan=11 → out_l=255, out_r=-256.
- Saturation with OUT_W=9: 6×0x1FF pan=11 → out_l=out_r=255, sat_flag=1 and stays 1 after following quiet frame.
- Full FIFO: sample_ready=0, push 5 frames → level=4, drop_cnt=1, first four frames pop in order; at full assert ready on completion edge → no drop, level stays 4.
- frame_sync at idx 3 with valid input 0x120 → partial discarded, frame completes 5 inputs later with sum including 0x120 (+32) as channel 0.
- Reset asserted at idx 4 with 2 frames queued → next cycle all outputs 0, level=0; fresh 6-channel frame produces correct sum.

Source files
------------

// File: rtl/ym_pkg.sv
// ---------------------------------------------------------------------------
// ym_pkg
// Shared helpers for the stereo frame accumulator:
//   - offsetToSigned : offset-binary channel sample to a wide signed value
//   - saturate       : clamp a wide signed value into an outW-bit signed range
//   - PAN_L / PAN_R  : bit positions of the left/right enables in ch_pan
// Helpers work on a fixed wide type so callers of any width can slice the
// result down to what they need.
// ---------------------------------------------------------------------------
package ym_pkg;

   localparam int MAX_W = 64;
   localparam int PAN_L = 1;
   localparam int PAN_R = 0;

   typedef logic signed [MAX_W-1:0] wide_t;

   // Flipping the MSB of an offset-binary code gives two's complement; the
   // flipped MSB is then replicated upward as the sign extension.
   function automatic wide_t offsetToSigned(input logic [MAX_W-1:0] value, input int inW);
      wide_t result;
      result = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < inW - 1)
            result[i] = value[i];
         else
            result[i] = ~value[inW-1];
      end
      return result;
   endfunction

   // Clamp to [-(2^(outW-1)), 2^(outW-1)-1]. The caller detects clipping by
   // comparing the result against the input.
   function automatic wide_t saturate(input wide_t value, input int outW);
      wide_t maxV;
      wide_t minV;
      maxV = (wide_t'(1) <<< (outW - 1)) - wide_t'(1);
      minV = -maxV - wide_t'(1);
      if (value > maxV)
         return maxV;
      else if (value < minV)
         return minV;
      return value;
   endfunction

endpackage

// File: rtl/ym_frame_fifo.sv
// ---------------------------------------------------------------------------
// ym_frame_fifo
// Small frame FIFO with a registered head word.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_push/i_pushData: write request and data (ignored when full unless a
//                      pop happens on the same edge)
//   i_pop            : remove the head word (ignored when empty)
//   o_headData       : registered head; holds the last popped word when empty
//   o_valid          : head word is valid (FIFO not empty)
//   o_full           : all DEPTH entries occupied
//   o_level          : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module ym_frame_fifo
   import ym_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_pushData,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_headData,
   output logic                     o_valid,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W:0]   r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_empty;
   logic             w_full;
   logic             w_doPop;
   logic             w_doPush;
   logic [PTR_W-1:0] w_nextRd;

   // Pop is decided first so that a push into a full FIFO can use the slot
   // freed by a pop on the same edge.
   always_comb begin
      w_empty  = (r_count == '0);
      w_full   = (r_count == (PTR_W+1)'(DEPTH));
      w_doPop  = i_pop && !w_empty;
      w_doPush = i_push && (!w_full || w_doPop);
      w_nextRd = r_rdPtr + PTR_W'(1);
   end

   // Pointers, occupancy and the head register. The head is reloaded from
   // the entry behind it on a pop, or straight from the push data when the
   // pushed word is the only one left; otherwise it keeps its old value so
   // an empty FIFO still shows the last popped word.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         if (w_doPush)
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_doPop)
            r_rdPtr <= w_nextRd;

         if (w_doPush && !w_doPop)
            r_count <= r_count + (PTR_W+1)'(1);
         else if (w_doPop && !w_doPush)
            r_count <= r_count - (PTR_W+1)'(1);

         if (w_doPop) begin
            if (r_count > (PTR_W+1)'(1))
               r_head <= r_mem[w_nextRd];
            else if (w_doPush)
               r_head <= i_pushData;
         end else if (w_empty && w_doPush) begin
            r_head <= i_pushData;
         end
      end
   end

   // Storage needs no reset: occupancy alone decides what is meaningful.
   always_ff @(posedge i_clk) begin
      if (w_doPush)
         r_mem[r_wrPtr] <= i_pushData;
   end

   assign o_headData = r_head;
   assign o_valid    = !w_empty;
   assign o_full     = w_full;
   assign o_level    = r_count;

endmodule

// File: rtl/ym_stereo_accum.sv
// ---------------------------------------------------------------------------
// ym_stereo_accum
// Sums CH_COUNT time-multiplexed channel samples into saturated signed
// left/right frame totals and queues finished frames in ym_frame_fifo.
// Ports:
//   MCLK, reset     : clock, synchronous active-high reset
//   ch_valid        : ch_value/ch_pan valid this cycle
//   ch_value        : offset-binary channel sample
//   ch_pan          : [1] left enable, [0] right enable
//   frame_sync      : restart the frame (with ch_valid: this input is ch 0)
//   sample_valid    : FIFO head valid
//   sample_ready    : consumer takes the head
//   out_l, out_r    : FIFO head samples, signed
//   sat_flag        : sticky, set when any completed frame was clamped
//   drop_cnt        : saturating count of frames lost to a full FIFO
//   level           : FIFO occupancy
// ---------------------------------------------------------------------------
module ym_stereo_accum
   import ym_pkg::*;
#(
   parameter int CH_COUNT   = 6,
   parameter int IN_W       = 9,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          MCLK,
   input  logic                          reset,
   input  logic                          ch_valid,
   input  logic [IN_W-1:0]               ch_value,
   input  logic [1:0]                    ch_pan,
   input  logic                          frame_sync,
   output logic                          sample_valid,
   input  logic                          sample_ready,
   output logic signed [OUT_W-1:0]       out_l,
   output logic signed [OUT_W-1:0]       out_r,
   output logic                          sat_flag,
   output logic [7:0]                    drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int IDX_W = $clog2(CH_COUNT);
   localparam int ACC_W = OUT_W + 1 + $clog2(CH_COUNT);

   logic signed [ACC_W-1:0] r_accL;
   logic signed [ACC_W-1:0] r_accR;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_satFlag;
   logic [7:0]              r_dropCnt;

   wide_t                   w_sample;
   wide_t                   w_sumL;
   wide_t                   w_sumR;
   wide_t                   w_clipL;
   wide_t                   w_clipR;
   logic signed [ACC_W-1:0] w_contribL;
   logic signed [ACC_W-1:0] w_contribR;
   logic                    w_lastCh;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_drop;
   logic                    w_clipped;
   logic [2*OUT_W-1:0]      w_pushData;
   logic [2*OUT_W-1:0]      w_headData;

   // Per-channel contribution and the finished-frame sums. The final sum is
   // built from the accumulator plus the current input so the frame can be
   // pushed on the same edge that samples the last channel.
   always_comb begin
      w_sample   = offsetToSigned({{(MAX_W-IN_W){1'b0}}, ch_value}, IN_W);
      w_contribL = ch_pan[PAN_L] ? w_sample[ACC_W-1:0] : '0;
      w_contribR = ch_pan[PAN_R] ? w_sample[ACC_W-1:0] : '0;
      w_lastCh   = (r_idx == IDX_W'(CH_COUNT - 1));
      w_push     = ch_valid && !frame_sync && w_lastCh;
      w_sumL     = wide_t'(r_accL) + wide_t'(w_contribL);
      w_sumR     = wide_t'(r_accR) + wide_t'(w_contribR);
      w_clipL    = saturate(w_sumL, OUT_W);
      w_clipR    = saturate(w_sumR, OUT_W);
      w_clipped  = (w_clipL != w_sumL) || (w_clipR != w_sumR);
      w_pushData = {w_clipL[OUT_W-1:0], w_clipR[OUT_W-1:0]};
      w_pop      = sample_valid && sample_ready;
      w_drop     = w_push && w_full && !w_pop;
   end

   // Channel counter and accumulators. frame_sync throws away any partial
   // frame; when it comes with a valid input that input starts the new
   // frame as channel 0, so the counter moves straight to 1.
   // Saturation and drop reporting happen on the frame completion edge.
   always_ff @(posedge MCLK) begin
      if (reset) begin
         r_accL    <= '0;
         r_accR    <= '0;
         r_idx     <= '0;
         r_satFlag <= 1'b0;
         r_dropCnt <= '0;
      end else begin
         if (frame_sync) begin
            r_idx  <= ch_valid ? IDX_W'(1) : '0;
            r_accL <= ch_valid ? w_contribL : '0;
            r_accR <= ch_valid ? w_contribR : '0;
         end else if (ch_valid) begin
            if (w_lastCh) begin
               r_idx  <= '0;
               r_accL <= '0;
               r_accR <= '0;
            end else begin
               r_idx  <= r_idx + IDX_W'(1);
               r_accL <= r_accL + w_contribL;
               r_accR <= r_accR + w_contribR;
            end
         end

         if (w_push && w_clipped)
            r_satFlag <= 1'b1;
         if (w_drop && (r_dropCnt != 8'hFF))
            r_dropCnt <= r_dropCnt + 8'd1;
      end
   end

   ym_frame_fifo #(
      .WIDTH (2*OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (MCLK),
      .i_reset    (reset),
      .i_push     (w_push),
      .i_pushData (w_pushData),
      .i_pop      (w_pop),
      .o_headData (w_headData),
      .o_valid    (sample_valid),
      .o_full     (w_full),
      .o_level    (level)
   );

   assign out_l    = w_headData[2*OUT_W-1:OUT_W];
   assign out_r    = w_headData[OUT_W-1:0];
   assign sat_flag = r_satFlag;
   assign drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_ym_stereo_accum.sv
// ---------------------------------------------------------------------------
// tb_ym_stereo_accum
// Directed bench for ym_stereo_accum: a default-parameter instance plus an
// OUT_W=9 instance (own reset) for clamping. Inputs are driven on the
// falling edge and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ym_stereo_accum;

   logic               MCLK;
   logic               reset;
   logic               resetSat;
   logic               chValid;
   logic [8:0]         chValue;
   logic [1:0]         chPan;
   logic               frameSync;
   logic               sampleReady;

   logic               sampleValid;
   logic signed [15:0] outL;
   logic signed [15:0] outR;
   logic               satFlag;
   logic [7:0]         dropCnt;
   logic [2:0]         level;

   logic               satValid;
   logic signed [8:0]  satL;
   logic signed [8:0]  satR;
   logic               satSat;
   logic [7:0]         satDrop;
   logic [2:0]         satLevel;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0][8:0] values;
      logic [5:0][1:0] pans;
      int              expL;
      int              expR;
   } frame_t;

   frame_t vectors [5];

   ym_stereo_accum dut (
      .MCLK         (MCLK),
      .reset        (reset),
      .ch_valid     (chValid),
      .ch_value     (chValue),
      .ch_pan       (chPan),
      .frame_sync   (frameSync),
      .sample_valid (sampleValid),
      .sample_ready (sampleReady),
      .out_l        (outL),
      .out_r        (outR),
      .sat_flag     (satFlag),
      .drop_cnt     (dropCnt),
      .level        (level)
   );

   ym_stereo_accum #(
      .CH_COUNT   (6),
      .IN_W       (9),
      .OUT_W      (9),
      .FIFO_DEPTH (4)
   ) dutSat (
      .MCLK         (MCLK),
      .reset        (resetSat),
      .ch_valid     (chValid),
      .ch_value     (chValue),
      .ch_pan       (chPan),
      .frame_sync   (frameSync),
      .sample_valid (satValid),
      .sample_ready (sampleReady),
      .out_l        (satL),
      .out_r        (satR),
      .sat_flag     (satSat),
      .drop_cnt     (satDrop),
      .level        (satLevel)
   );

   // Free-running 10-unit clock.
   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   // One comparison: bumps the total and reports a mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Drives one channel input at the next falling edge.
   task automatic applyStimulus(input logic [8:0] value, input logic [1:0] pan, input logic sync);
      @(negedge MCLK);
      chValid   = 1'b1;
      chValue   = value;
      chPan     = pan;
      frameSync = sync;
   endtask

   // Drops ch_valid at the next falling edge (just after the last sample).
   task automatic idle();
      @(negedge MCLK);
      chValid   = 1'b0;
      frameSync = 1'b0;
   endtask

   // Six identical channels followed by one idle cycle.
   task automatic sendFrame(input logic [8:0] value, input logic [1:0] pan);
      for (int i = 0; i < 6; i++)
         applyStimulus(value, pan, 1'b0);
      idle();
   endtask

   // Table frame with latency checks: nothing valid before the completion
   // edge, the frame at the head right after it.
   task automatic runFrame(input frame_t f, input int k);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(f.values[i], f.pans[i], 1'b0);
         if (i == 5)
            checkOutput($sformatf("vec%0d_pre_valid", k), int'(sampleValid), 0);
      end
      idle();
      checkOutput($sformatf("vec%0d_valid", k), int'(sampleValid), 1);
      checkOutput($sformatf("vec%0d_out_l", k), int'(outL), f.expL);
      checkOutput($sformatf("vec%0d_out_r", k), int'(outR), f.expR);
      checkOutput($sformatf("vec%0d_level", k), int'(level), 1);
   endtask

   initial begin
      vectors[0].values = {6{9'h110}};
      vectors[0].pans   = {6{2'b11}};
      vectors[0].expL   = 96;
      vectors[0].expR   = 96;

      vectors[1].values    = {6{9'h100}};
      vectors[1].pans      = {6{2'b11}};
      vectors[1].values[0] = 9'h1FF;
      vectors[1].pans[0]   = 2'b10;
      vectors[1].values[1] = 9'h000;
      vectors[1].pans[1]   = 2'b01;
      vectors[1].expL      = 255;
      vectors[1].expR      = -256;

      vectors[2].values = {6{9'h100}};
      vectors[2].pans   = {6{2'b11}};
      vectors[2].expL   = 0;
      vectors[2].expR   = 0;

      vectors[3].values = {6{9'h000}};
      vectors[3].pans   = {6{2'b10}};
      vectors[3].expL   = -1536;
      vectors[3].expR   = 0;

      vectors[4].values = {9'h106, 9'h105, 9'h104, 9'h103, 9'h102, 9'h101};
      vectors[4].pans   = {2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11};
      vectors[4].expL   = 14;
      vectors[4].expR   = 13;

      reset       = 1'b1;
      resetSat    = 1'b1;
      chValid     = 1'b0;
      chValue     = '0;
      chPan       = '0;
      frameSync   = 1'b0;
      sampleReady = 1'b1;
      repeat (3) @(negedge MCLK);
      reset    = 1'b0;
      resetSat = 1'b0;

      checkOutput("rst_valid", int'(sampleValid), 0);
      checkOutput("rst_level", int'(level), 0);
      checkOutput("rst_out_l", int'(outL), 0);
      checkOutput("rst_out_r", int'(outR), 0);
      checkOutput("rst_sat", int'(satFlag), 0);
      checkOutput("rst_drop", int'(dropCnt), 0);

      for (int k = 0; k < 5; k++)
         runFrame(vectors[k], k);
      checkOutput("no_sat_16bit", int'(satFlag), 0);

      // Clamping on the 9-bit instance, both directions, sticky flag.
      @(negedge MCLK);
      resetSat = 1'b1;
      @(negedge MCLK);
      resetSat = 1'b0;
      checkOutput("sat_rst_flag", int'(satSat), 0);
      sendFrame(9'h1FF, 2'b11);
      checkOutput("sat_hi_l", int'(satL), 255);
      checkOutput("sat_hi_r", int'(satR), 255);
      checkOutput("sat_hi_flag", int'(satSat), 1);
      checkOutput("wide_hi_l", int'(outL), 1530);
      sendFrame(9'h100, 2'b11);
      checkOutput("sat_quiet_l", int'(satL), 0);
      checkOutput("sat_quiet_flag", int'(satSat), 1);
      sendFrame(9'h000, 2'b11);
      checkOutput("sat_lo_l", int'(satL), -256);
      checkOutput("sat_lo_r", int'(satR), -256);
      checkOutput("wide_lo_l", int'(outL), -1536);
      checkOutput("wide_no_sat", int'(satFlag), 0);

      // Full FIFO: four frames fit, the fifth is dropped.
      @(negedge MCLK);
      sampleReady = 1'b0;
      for (int k = 0; k < 5; k++)
         sendFrame(9'(9'h101 + k), 2'b11);
      checkOutput("full_level", int'(level), 4);
      checkOutput("full_drop", int'(dropCnt), 1);
      checkOutput("full_valid", int'(sampleValid), 1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("full_order%0d", k), int'(outL), 6 * (k + 1));
         sampleReady = 1'b1;
         @(negedge MCLK);
         sampleReady = 1'b0;
      end
      checkOutput("drain_valid", int'(sampleValid), 0);
      checkOutput("drain_level", int'(level), 0);
      checkOutput("drain_hold_l", int'(outL), 24);

      // Full FIFO with a pop on the completion edge: no drop.
      for (int k = 0; k < 4; k++)
         sendFrame(9'(9'h101 + k), 2'b11);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(9'h105, 2'b11, 1'b0);
         if (i == 5)
            sampleReady = 1'b1;
      end
      idle();
      sampleReady = 1'b0;
      checkOutput("popfull_level", int'(level), 4);
      checkOutput("popfull_drop", int'(dropCnt), 1);
      checkOutput("popfull_head", int'(outL), 12);
      sampleReady = 1'b1;
      repeat (4) @(negedge MCLK);
      checkOutput("popfull_drain_level", int'(level), 0);
      checkOutput("popfull_last", int'(outL), 30);

      // frame_sync with a valid input at idx 3.
      for (int i = 0; i < 3; i++)
         applyStimulus(9'h150, 2'b11, 1'b0);
      applyStimulus(9'h120, 2'b11, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(9'h101, 2'b10, 1'b0);
         checkOutput($sformatf("sync_pre%0d", i), int'(sampleValid), 0);
      end
      idle();
      checkOutput("sync_valid", int'(sampleValid), 1);
      checkOutput("sync_l", int'(outL), 37);
      checkOutput("sync_r", int'(outR), 32);

      // frame_sync without a valid input clears the partial frame.
      for (int i = 0; i < 3; i++)
         applyStimulus(9'h150, 2'b11, 1'b0);
      @(negedge MCLK);
      chValid   = 1'b0;
      frameSync = 1'b1;
      sendFrame(9'h102, 2'b11);
      checkOutput("sync_novalid_valid", int'(sampleValid), 1);
      checkOutput("sync_novalid_l", int'(outL), 12);

      // Reset mid-frame with two frames queued.
      @(negedge MCLK);
      sampleReady = 1'b0;
      sendFrame(9'h101, 2'b11);
      sendFrame(9'h102, 2'b11);
      checkOutput("prereset_level", int'(level), 2);
      for (int i = 0; i < 4; i++)
         applyStimulus(9'h150, 2'b11, 1'b0);
      @(negedge MCLK);
      reset   = 1'b1;
      chValue = 9'h1FF;
      @(negedge MCLK);
      reset   = 1'b0;
      chValid = 1'b0;
      checkOutput("midrst_level", int'(level), 0);
      checkOutput("midrst_valid", int'(sampleValid), 0);
      checkOutput("midrst_out_l", int'(outL), 0);
      checkOutput("midrst_out_r", int'(outR), 0);
      checkOutput("midrst_drop", int'(dropCnt), 0);
      sampleReady = 1'b1;
      sendFrame(9'h110, 2'b11);
      checkOutput("postrst_valid", int'(sampleValid), 1);
      checkOutput("postrst_l", int'(outL), 96);
      checkOutput("postrst_r", int'(outR), 96);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
